// File: rtl/d_latch_q_monitor.sv
// d_latch_q_monitor: synchronize, glitch-filter and measure latch output q; MON_SATURATE_EN makes edge counters saturate
module d_latch_q_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_q,
  input  logic             i_clr,
  output logic             o_q_filt,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_rise_cnt,
  output logic [CNT_W-1:0] o_fall_cnt,
  output logic [CNT_W-1:0] o_high_len,
  output logic             o_len_valid
);
  typedef enum logic [1:0] {ST_LOW, ST_CHK_H, ST_HIGH, ST_CHK_L} state_t;
  localparam logic [7:0] STAB_LAST = 8'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0] r_stab, w_stab_nxt;
  logic [CNT_W-1:0] r_wlen, w_wlen_inc, w_rise_inc, w_fall_inc;
  logic w_s_q, w_rise, w_fall, w_filt_nxt;
  assign w_s_q = r_sync[SYNC_STAGES-1];
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    case (r_state)
      ST_LOW: if (w_s_q) begin
        w_state_nxt = ST_CHK_H;
        w_stab_nxt  = 8'd1;
      end
      ST_CHK_H: if (!w_s_q) begin
        w_state_nxt = ST_LOW;
        w_stab_nxt  = 8'd0;
      end else if (r_stab == STAB_LAST) begin
        w_state_nxt = ST_HIGH;
        w_stab_nxt  = 8'd0;
      end else w_stab_nxt = r_stab + 8'd1;
      ST_HIGH: if (!w_s_q) begin
        w_state_nxt = ST_CHK_L;
        w_stab_nxt  = 8'd1;
      end
      ST_CHK_L: if (w_s_q) begin
        w_state_nxt = ST_HIGH;
        w_stab_nxt  = 8'd0;
      end else if (r_stab == STAB_LAST) begin
        w_state_nxt = ST_LOW;
        w_stab_nxt  = 8'd0;
      end else w_stab_nxt = r_stab + 8'd1;
      default: begin
        w_state_nxt = ST_LOW;
        w_stab_nxt  = 8'd0;
      end
    endcase
  end
  assign w_rise     = (r_state == ST_CHK_H) && (w_state_nxt == ST_HIGH);
  assign w_fall     = (r_state == ST_CHK_L) && (w_state_nxt == ST_LOW);
  assign w_filt_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_CHK_L);
  assign w_wlen_inc = (&r_wlen) ? r_wlen : r_wlen + ONE;
`ifdef MON_SATURATE_EN
  assign w_rise_inc = (&o_rise_cnt) ? o_rise_cnt : o_rise_cnt + ONE;
  assign w_fall_inc = (&o_fall_cnt) ? o_fall_cnt : o_fall_cnt + ONE;
`else
  assign w_rise_inc = o_rise_cnt + ONE;
  assign w_fall_inc = o_fall_cnt + ONE;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= '0;
      r_state     <= ST_LOW;
      r_stab      <= '0;
      r_wlen      <= '0;
      o_q_filt    <= 1'b0;
      o_rise      <= 1'b0;
      o_fall      <= 1'b0;
      o_len_valid <= 1'b0;
      o_rise_cnt  <= '0;
      o_fall_cnt  <= '0;
      o_high_len  <= '0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_q};
      r_state     <= w_state_nxt;
      r_stab      <= w_stab_nxt;
      r_wlen      <= w_rise ? '0 : o_q_filt ? w_wlen_inc : r_wlen;
      o_q_filt    <= w_filt_nxt;
      o_rise      <= w_rise;
      o_fall      <= w_fall;
      o_len_valid <= w_fall;
      o_rise_cnt  <= i_clr ? '0 : w_rise ? w_rise_inc : o_rise_cnt;
      o_fall_cnt  <= i_clr ? '0 : w_fall ? w_fall_inc : o_fall_cnt;
      o_high_len  <= i_clr ? '0 : w_fall ? w_wlen_inc : o_high_len;
    end
  end
endmodule

// File: tb/tb_d_latch_q_monitor.sv
// tb_d_latch_q_monitor: random and directed stimulus against a run-length reference model
module tb_d_latch_q_monitor;
  localparam int SYNC = 2, FILT = 4, W = 4, MAX = (1 << W) - 1;
  logic clk = 1'b0, rst = 1'b1, q = 1'b0, clr = 1'b0;
  logic o_q_filt, o_rise, o_fall, o_len_valid;
  logic [W-1:0] o_rise_cnt, o_fall_cnt, o_high_len;
  int n_vec = 0, n_err = 0;
  bit m_sync[$];
  bit m_filt, m_rise, m_fall, m_valid;
  int m_run, m_wlen, m_rc, m_fc, m_hl;
  int r_at, f_at, v_at, hl_v, hi_cnt, edges;
  d_latch_q_monitor #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .CNT_W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_q(q), .i_clr(clr),
    .o_q_filt(o_q_filt), .o_rise(o_rise), .o_fall(o_fall),
    .o_rise_cnt(o_rise_cnt), .o_fall_cnt(o_fall_cnt), .o_high_len(o_high_len),
    .o_len_valid(o_len_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int bump(input int v);
`ifdef MON_SATURATE_EN
    return (v == MAX) ? MAX : v + 1;
`else
    return (v + 1) & MAX;
`endif
  endfunction
  task automatic model_step();
    bit s, old;
    if (rst) begin
      m_sync = {};
      repeat (SYNC) m_sync.push_back(1'b0);
      {m_filt, m_rise, m_fall, m_valid} = '0;
      {m_run, m_wlen, m_rc, m_fc, m_hl} = '0;
    end else begin
      s = m_sync.pop_front();
      m_sync.push_back(q);
      old = m_filt;
      m_rise = 0;
      m_fall = 0;
      m_run = (s != m_filt) ? m_run + 1 : 0;
      if (m_run == FILT) begin
        m_run = 0;
        m_filt = s;
        m_rise = s;
        m_fall = !s;
      end
      if (m_rise) m_wlen = 0;
      else if (old) m_wlen = (m_wlen == MAX) ? MAX : m_wlen + 1;
      m_valid = m_fall;
      m_hl = clr ? 0 : m_fall ? m_wlen : m_hl;
      m_rc = clr ? 0 : m_rise ? bump(m_rc) : m_rc;
      m_fc = clr ? 0 : m_fall ? bump(m_fc) : m_fc;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("q_filt", o_q_filt, m_filt);
    check("rise", o_rise, m_rise);
    check("fall", o_fall, m_fall);
    check("len_valid", o_len_valid, m_valid);
    check("rise_cnt", o_rise_cnt, m_rc);
    check("fall_cnt", o_fall_cnt, m_fc);
    check("high_len", o_high_len, m_hl);
    edges += int'(o_rise) + int'(o_fall);
  endtask
  task automatic run_pulse(input int hi, input int lo);
    {r_at, f_at, v_at, hl_v, hi_cnt} = '0;
    for (int k = 1; k <= hi + lo; k++) begin
      q = (k <= hi);
      tick();
      if (o_rise && r_at == 0) r_at = k;
      if (o_fall && f_at == 0) f_at = k;
      if (o_len_valid && v_at == 0) begin
        v_at = k;
        hl_v = int'(o_high_len);
      end
      hi_cnt += int'(o_q_filt);
    end
  endtask
  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  initial begin
    q = 1'b1;
    repeat (3) begin
      tick();
      check("rst_all", {o_q_filt, o_rise, o_fall, o_len_valid, o_rise_cnt, o_fall_cnt, o_high_len}, 0);
    end
    rst = 1'b0;
    r_at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) check("post_rst_all", {o_q_filt, o_rise, o_high_len}, 0);
      if (o_q_filt && r_at == 0) r_at = k;
    end
    check("rst_latency", r_at, SYNC + FILT);
    q = 1'b0;
    repeat (10) tick();
    clear();
    edges = 0;
    q = 1'b1;
    repeat (3) tick();
    q = 1'b0;
    repeat (10) tick();
    check("glitch_edges", edges, 0);
    check("glitch_rcnt", o_rise_cnt, 0);
    run_pulse(10, 12);
    check("pulse_rise_at", r_at, SYNC + FILT);
    check("pulse_high_cycles", hi_cnt, 10);
    check("pulse_fall_at", f_at, SYNC + FILT + 10);
    check("pulse_valid_at", v_at, f_at);
    check("pulse_high_len", hl_v, 10);
    check("pulse_counts", {o_rise_cnt, o_fall_cnt}, {4'd1, 4'd1});
    run_pulse(20, 12);
    check("sat_high_len", hl_v, MAX);
    clear();
    repeat (5) run_pulse(8, 8);
    check("pre_clr_rcnt", o_rise_cnt, 5);
    q = 1'b1;
    repeat (SYNC + FILT - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_hit_rise", o_rise, 1);
    check("clr_hit_rcnt", o_rise_cnt, 0);
    check("clr_hit_filt", o_q_filt, 1);
    repeat (3) tick();
    q = 1'b0;
    repeat (10) tick();
    clear();
    repeat (17) run_pulse(8, 8);
`ifdef MON_SATURATE_EN
    check("wrap_rcnt", o_rise_cnt, 15);
    check("wrap_fcnt", o_fall_cnt, 15);
`else
    check("wrap_rcnt", o_rise_cnt, 1);
    check("wrap_fcnt", o_fall_cnt, 1);
`endif
    q = 1'b1;
    repeat (SYNC + FILT + 2) tick();
    check("midhigh_filt", o_q_filt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midhigh_rst", {o_q_filt, o_fall, o_len_valid, o_rise_cnt, o_fall_cnt}, 0);
    edges = 0;
    for (int n = 0; n < 60; n++) begin
      q = ((2 * n) / 3) % 2 == 1;
      tick();
    end
    check("latch_edges", edges, 0);
    for (int n = 0; n < 400; n++) begin
      q = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(1, 12)) begin
        clr = $urandom_range(0, 15) == 0;
        rst = $urandom_range(0, 99) == 0;
        tick();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
